// File: rtl/multi_debounce.sv
// N-channel contact debouncer: 2-FF synchroniser, stability filter, edge pulses
// and a saturating long-press detector per channel.
module multi_debounce #(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned STABLE_CYCLES = 500000,
   parameter int unsigned CNT_W         = 20,
   parameter int unsigned HOLD_CYCLES   = 50000000,
   parameter int unsigned HOLD_W        = 26,
   parameter bit          INIT_LEVEL    = 1'b0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] debounced,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] held,
   output logic [N_CH-1:0] long_press
);

   localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES);
   localparam logic [N_CH-1:0]   INIT_VEC    = {N_CH{INIT_LEVEL}};

   // Terminal counts must be nonzero and fit their counters exactly.
   if (N_CH == 0 || CNT_W == 0 || HOLD_W == 0 ||
       STABLE_CYCLES == 0 || HOLD_CYCLES == 0 ||
       64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
       64'(HOLD_CYCLES) > ((64'd1 << HOLD_W) - 64'd1)) begin : g_bad_params
      $error("multi_debounce: illegal parameter combination");
   end

   logic [N_CH-1:0]   r_s1;
   logic [N_CH-1:0]   r_s2;
   logic [N_CH-1:0]   r_deb;
   logic [N_CH-1:0]   r_rise;
   logic [N_CH-1:0]   r_fall;
   logic [N_CH-1:0]   r_held;
   logic [N_CH-1:0]   r_lp;
   logic [CNT_W-1:0]  r_cnt      [N_CH];
   logic [HOLD_W-1:0] r_hcnt     [N_CH];

   logic [CNT_W-1:0]  w_cnt_nxt  [N_CH];
   logic [HOLD_W-1:0] w_hcnt_nxt [N_CH];
   logic [N_CH-1:0]   w_flip;
   logic [N_CH-1:0]   w_deb_nxt;
   logic [N_CH-1:0]   w_hit;

   // Two-stage synchroniser; only r_s2 is seen by the filter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= INIT_VEC;
         r_s2 <= INIT_VEC;
      end else begin
         r_s1 <= raw_in;
         r_s2 <= r_s1;
      end
   end

   // Stability and hold counter next-state per channel.
   always_comb begin
      w_flip    = '0;
      w_deb_nxt = r_deb;
      w_hit     = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         w_cnt_nxt[i]  = '0;
         w_hcnt_nxt[i] = '0;
         if (r_s2[i] != r_deb[i]) begin
            if (r_cnt[i] == STABLE_LAST) begin
               w_flip[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
         end
         w_deb_nxt[i] = r_deb[i] ^ w_flip[i];
         // Count only cycles already high, so hcnt is 0 on the rise cycle
         // and cleared on the same edge as a fall.
         if (r_deb[i] && w_deb_nxt[i]) begin
            w_hcnt_nxt[i] = (r_hcnt[i] == HOLD_LAST) ? r_hcnt[i]
                                                     : r_hcnt[i] + HOLD_W'(1);
         end
         w_hit[i] = w_deb_nxt[i] && (w_hcnt_nxt[i] == HOLD_LAST);
      end
   end

   // Filter, pulse and hold registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_deb  <= INIT_VEC;
         r_rise <= '0;
         r_fall <= '0;
         r_held <= '0;
         r_lp   <= '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            r_cnt[i]  <= '0;
            r_hcnt[i] <= '0;
         end
      end else begin
         r_deb  <= w_deb_nxt;
         r_rise <= w_flip & w_deb_nxt;
         r_fall <= w_flip & ~w_deb_nxt;
         r_held <= w_hit;
         r_lp   <= w_hit & ~r_held;
         for (int i = 0; i < int'(N_CH); i++) begin
            r_cnt[i]  <= w_cnt_nxt[i];
            r_hcnt[i] <= w_hcnt_nxt[i];
         end
      end
   end

   assign debounced  = r_deb;
   assign rise       = r_rise;
   assign fall       = r_fall;
   assign held       = r_held;
   assign long_press = r_lp;

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed vector table, timed corner sequences and
// randomized traffic against a history-window reference model.
module tb_multi_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] raw_a, deb_a, rise_a, fall_a, held_a, lp_a;
   logic [2:0] raw_b, deb_b, rise_b, fall_b, held_b, lp_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   multi_debounce #(
      .N_CH(2), .STABLE_CYCLES(4), .CNT_W(3),
      .HOLD_CYCLES(10), .HOLD_W(4), .INIT_LEVEL(1'b0)
   ) u_a (
      .clk(clk), .reset_n(rst_n), .raw_in(raw_a), .debounced(deb_a),
      .rise(rise_a), .fall(fall_a), .held(held_a), .long_press(lp_a)
   );

   multi_debounce #(
      .N_CH(3), .STABLE_CYCLES(1), .CNT_W(1),
      .HOLD_CYCLES(3), .HOLD_W(2), .INIT_LEVEL(1'b1)
   ) u_b (
      .clk(clk), .reset_n(rst_n), .raw_in(raw_b), .debounced(deb_b),
      .rise(rise_b), .fall(fall_b), .held(held_b), .long_press(lp_b)
   );

   // Reference model: output flips once the last STABLE synchronised samples
   // all disagree with it; hold status comes from the age of the last rise.
   bit          m_s1   [2][3];
   bit          m_s2   [2][3];
   bit          m_deb  [2][3];
   bit          m_rise [2][3];
   bit          m_fall [2][3];
   bit          m_held [2][3];
   bit          m_lp   [2][3];
   int unsigned m_hist [2][3];
   int          m_nval [2][3];
   int          m_redge[2][3];
   int          m_edge [2];

   function automatic int s_of(input int k);  return (k == 0) ? 4 : 1;  endfunction
   function automatic int h_of(input int k);  return (k == 0) ? 10 : 3; endfunction
   function automatic int n_of(input int k);  return (k == 0) ? 2 : 3;  endfunction
   function automatic bit i_of(input int k);  return k != 0;            endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_edge[k] = 0;
         for (int i = 0; i < 3; i++) begin
            m_s1[k][i] = i_of(k);  m_s2[k][i] = i_of(k);  m_deb[k][i] = i_of(k);
            m_rise[k][i] = 0;  m_fall[k][i] = 0;  m_held[k][i] = 0;  m_lp[k][i] = 0;
            m_hist[k][i] = 0;  m_nval[k][i] = 0;  m_redge[k][i] = 0;
         end
      end
   endtask

   task automatic model_edge();
      logic [2:0]  rv;
      bit          s2p, flip;
      int unsigned mask;
      int          age;
      for (int k = 0; k < 2; k++) begin
         rv = (k == 0) ? {1'b0, raw_a} : raw_b;
         m_edge[k]++;
         for (int i = 0; i < n_of(k); i++) begin
            s2p        = m_s2[k][i];
            m_s2[k][i] = m_s1[k][i];
            m_s1[k][i] = rv[i];
            m_hist[k][i] = (m_hist[k][i] << 1) | 32'(s2p);
            if (m_nval[k][i] < 32) m_nval[k][i]++;
            mask = (32'd1 << s_of(k)) - 32'd1;
            flip = (m_nval[k][i] >= s_of(k)) &&
                   ((m_hist[k][i] & mask) == (m_deb[k][i] ? 32'd0 : mask));
            m_rise[k][i] = flip && !m_deb[k][i];
            m_fall[k][i] = flip && m_deb[k][i];
            if (flip) begin
               m_deb[k][i] = !m_deb[k][i];
               if (m_deb[k][i]) m_redge[k][i] = m_edge[k];
            end
            age = m_edge[k] - m_redge[k][i];
            m_held[k][i] = m_deb[k][i] && (age >= h_of(k));
            m_lp[k][i]   = m_deb[k][i] && (age == h_of(k));
         end
      end
   endtask

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic compare_model();
      logic [2:0] ed, er, ef, eh, el;
      for (int k = 0; k < 2; k++) begin
         ed = '0; er = '0; ef = '0; eh = '0; el = '0;
         for (int i = 0; i < n_of(k); i++) begin
            ed[i] = m_deb[k][i];  er[i] = m_rise[k][i];  ef[i] = m_fall[k][i];
            eh[i] = m_held[k][i]; el[i] = m_lp[k][i];
         end
         if (k == 0) begin
            check("a_debounced", {1'b0, deb_a}, ed);
            check("a_rise",      {1'b0, rise_a}, er);
            check("a_fall",      {1'b0, fall_a}, ef);
            check("a_held",      {1'b0, held_a}, eh);
            check("a_long_press",{1'b0, lp_a}, el);
         end else begin
            check("b_debounced", deb_b, ed);
            check("b_rise",      rise_b, er);
            check("b_fall",      fall_b, ef);
            check("b_held",      held_b, eh);
            check("b_long_press",lp_b, el);
         end
      end
   endtask

   // One clock: model advances on the edge, outputs compared 1 time unit later.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      compare_model();
   endtask

   // Asynchronous assert wherever we are in the cycle; release on a falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_a_debounced", {1'b0, deb_a}, 3'b000);
      check("rst_b_debounced", deb_b, 3'b111);
      check("rst_a_others", {1'b0, rise_a | fall_a | held_a | lp_a}, 3'b000);
      check("rst_b_others", rise_b | fall_b | held_b | lp_b, 3'b000);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic bit cond(input int w);
      case (w)
         0:       return rise_a[0];
         1:       return rise_a != 2'b00;
         2:       return lp_a[1];
         3:       return fall_a != 2'b00;
         4:       return fall_b[0];
         5:       return rise_a[1];
         default: return 1'b0;
      endcase
   endfunction

   // Steps until the condition holds; -1 if it never does within the budget.
   task automatic count_until(input int w, output int n);
      n = -1;
      for (int j = 1; j <= 60; j++) begin
         step();
         if (cond(w)) begin
            n = j;
            break;
         end
      end
   endtask

   typedef struct {
      logic [1:0] raw;
      int         cycles;
      logic [1:0] exp_deb;
      logic [1:0] exp_held;
      logic [1:0] exp_rise;
      logic [1:0] exp_fall;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int         n;
      logic [1:0] acc_r, acc_f, acc_l;
      logic [2:0] acc_b;

      vecs[0]  = '{2'b01, 6, 2'b01, 2'b00, 2'b01, 2'b00};
      vecs[1]  = '{2'b01, 9, 2'b01, 2'b00, 2'b00, 2'b00};
      vecs[2]  = '{2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b00};
      vecs[3]  = '{2'b11, 5, 2'b01, 2'b01, 2'b00, 2'b00};
      vecs[4]  = '{2'b11, 1, 2'b11, 2'b01, 2'b10, 2'b00};
      vecs[5]  = '{2'b10, 6, 2'b10, 2'b00, 2'b00, 2'b01};
      vecs[6]  = '{2'b10, 4, 2'b10, 2'b10, 2'b00, 2'b00};
      vecs[7]  = '{2'b00, 3, 2'b10, 2'b10, 2'b00, 2'b00};
      vecs[8]  = '{2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b10};
      vecs[9]  = '{2'b01, 3, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[10] = '{2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[11] = '{2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[12] = '{2'b01, 1, 2'b01, 2'b00, 2'b01, 2'b00};

      rst_n = 1'b1;
      raw_a = '0;
      raw_b = '0;
      model_reset();
      #2;

      // Vector table, including a bounce that must restart qualification.
      do_reset();
      for (int v = 0; v < 13; v++) begin
         raw_a = vecs[v].raw;
         acc_r = '0;
         acc_f = '0;
         for (int c = 0; c < vecs[v].cycles; c++) begin
            step();
            acc_r |= rise_a;
            acc_f |= fall_a;
         end
         check($sformatf("vec%0d_debounced", v), {1'b0, deb_a}, {1'b0, vecs[v].exp_deb});
         check($sformatf("vec%0d_held", v),      {1'b0, held_a}, {1'b0, vecs[v].exp_held});
         check($sformatf("vec%0d_rise_seen", v), {1'b0, acc_r}, {1'b0, vecs[v].exp_rise});
         check($sformatf("vec%0d_fall_seen", v), {1'b0, acc_f}, {1'b0, vecs[v].exp_fall});
      end

      // Single channel latency and one-cycle rise pulse.
      raw_a = 2'b00;
      do_reset();
      raw_a = 2'b01;
      count_until(0, n);
      check_int("rise0_latency", n, 6);
      check("rise0_value", {1'b0, rise_a}, 3'b001);
      check("rise0_debounced", {1'b0, deb_a}, 3'b001);
      step();
      check("rise0_one_cycle", {1'b0, rise_a}, 3'b000);

      // Simultaneous channels rise and fall on the same edges.
      raw_a = 2'b00;
      do_reset();
      raw_a = 2'b11;
      count_until(1, n);
      check_int("simul_rise_latency", n, 6);
      check("simul_rise_value", {1'b0, rise_a}, 3'b011);
      raw_a = 2'b00;
      count_until(3, n);
      check_int("simul_fall_latency", n, 6);
      check("simul_fall_value", {1'b0, fall_a}, 3'b011);

      // Long press: single pulse, held persists, clears with the fall.
      raw_a = 2'b00;
      do_reset();
      raw_a = 2'b10;
      count_until(5, n);
      check_int("lp_rise_latency", n, 6);
      count_until(2, n);
      check_int("lp_after_rise", n, 10);
      check("lp_held_set", {1'b0, held_a}, 3'b010);
      acc_l = '0;
      repeat (15) begin
         step();
         acc_l |= lp_a;
      end
      check("lp_no_refire", {1'b0, acc_l}, 3'b000);
      check("lp_held_stays", {1'b0, held_a}, 3'b010);
      raw_a = 2'b00;
      count_until(3, n);
      check_int("lp_fall_latency", n, 6);
      check("lp_fall_value", {1'b0, fall_a}, 3'b010);
      check("lp_held_cleared", {1'b0, held_a}, 3'b000);

      // Reset in the middle of a qualification count.
      raw_a = 2'b00;
      do_reset();
      raw_a = 2'b01;
      repeat (3) step();
      #2;
      do_reset();
      count_until(0, n);
      check_int("midreset_rise_latency", n, 6);

      // Active-low style instance: no pulses out of reset, fast fall.
      raw_b = 3'b111;
      do_reset();
      acc_b = '0;
      repeat (5) begin
         step();
         acc_b |= rise_b | fall_b;
      end
      check("initlvl_no_pulses", acc_b, 3'b000);
      raw_b = 3'b110;
      count_until(4, n);
      check_int("initlvl_fall_latency", n, 3);

      // Randomized traffic on both instances with one reset mid-stream.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 2; i++)
            if ($urandom_range(0, 11) == 0) raw_a[i] = ~raw_a[i];
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 3) == 0) raw_b[i] = ~raw_b[i];
         if (c == 750) begin
            #3;
            do_reset();
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/multi_debounce.md
Name: multi_debounce

Overview:
Parametrised N-channel debouncer for buttons, switches and encoder contacts. Each channel has a 2-FF synchroniser and a programmable-length stability counter. Each channel produces a debounced level, one-cycle rise/fall pulses and a long-press flag. It sits between board inputs and the control FSMs and replaces per-input single-channel debounce instances.

Parameters:
N_CH, 4, number of independent input channels
STABLE_CYCLES, 500000, consecutive cycles the synchronised input must differ from the output before the output flips (10 ms at 50 MHz); legal range 1..2^CNT_W-1
CNT_W, 20, stability counter width
HOLD_CYCLES, 50000000, cycles debounced[i] must stay high before held[i] asserts (1 s at 50 MHz); legal range 1..2^HOLD_W-1
HOLD_W, 26, hold counter width
INIT_LEVEL, 0, reset value of the synchronisers and debounced outputs (1 for active-low buttons)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
raw_in  input  N_CH  asynchronous raw contact inputs
debounced  output  N_CH  filtered level per channel
rise  output  N_CH  one-cycle pulse when debounced[i] goes 0->1
fall  output  N_CH  one-cycle pulse when debounced[i] goes 1->0
held  output  N_CH  high while debounced[i] has been 1 for >= HOLD_CYCLES cycles
long_press  output  N_CH  one-cycle pulse on the cycle held[i] first asserts

Behaviour:
- Single clock clk; reset_n asynchronous assert, active low. Release is synchronous to clk at board level.
- Reset state: sync stages = INIT_LEVEL, debounced = {N_CH{INIT_LEVEL}}. Counters, rise, fall, held and long_press = 0.
- All channels are fully independent. No cross-channel state or arbitration. Simultaneous events on several channels are handled in parallel.
- Synchroniser: s1[i] <= raw_in[i], s2[i] <= s1[i]. Only s2 feeds the filter.
- Stability counter cnt[i], per clock:
  - s2 == debounced: cnt <= 0.
  - s2 != debounced and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s2 != debounced and cnt == STABLE_CYCLES-1: debounced <= s2, cnt <= 0.
- Net effect: the output flips only after s2 has held the new value for STABLE_CYCLES consecutive clocks. Any glitch back to the old value restarts the count from 0.
- Latency: raw_in changes and then stays stable; debounced changes exactly STABLE_CYCLES+2 clock edges after the first edge that samples the new raw value.
- rise/fall are registered.
  - rise[i] = 1 only in the first cycle debounced[i] reads 1.
  - fall[i] = 1 only in the first cycle debounced[i] reads 0.
  - Never both high; never high for two consecutive cycles on the same channel.
- Hold counter hcnt[i]:
  - Cleared while debounced[i] == 0.
  - Increments while debounced[i] == 1; saturates at HOLD_CYCLES. No wrap.
  - held[i] = (hcnt[i] == HOLD_CYCLES).
  - long_press[i] pulses for exactly one cycle, in the first cycle held[i] reads 1.
  - A release (debounced 1->0) clears hcnt and held in the same edge as the fall. long_press cannot re-fire until a new rise.
- Polarity: held/long_press track logical high of debounced. Active-low contacts use INIT_LEVEL=1 plus inversion at the consumer, or an inverted raw_in.
- Reset mid-operation: all state returns to reset values immediately. Partial counts are discarded. No rise/fall pulse is generated by reset itself.
- Raw held at !INIT_LEVEL through reset release: normal qualification follows. debounced flips STABLE_CYCLES+2 edges later with the corresponding rise/fall pulse.
- STABLE_CYCLES=1: output follows s2 with one extra cycle (3-edge latency); this is legal.
- Widths: counters compare at exact equality; CNT_W/HOLD_W must hold the terminal values. An elaboration-time assertion flags illegal parameter values.

Test Plan:
1. N_CH=2, STABLE_CYCLES=4, INIT_LEVEL=0; reset, then raw_in[0]=1 held -> debounced[0]=1 exactly 6 edges later; rise[0] high 1 cycle; channel 1 stays 0 with no pulses.
2. Bounce: raw_in[0] pattern 1,1,1,0,1,1,1,1 (one per cycle) -> debounced[0] rises 6 edges after the final 0->1 transition; no pulse before that; cnt restarts on the 0.
3. Simultaneous: raw_in=2'b11 in the same cycle -> both debounced bits and both rise bits assert on the same edge. Later raw_in=2'b00 -> both fall pulses on the same edge, 6 edges after the change.
4. Long press: HOLD_CYCLES=10, debounced[1] held high -> held[1] and a single long_press[1] pulse 10 cycles after rise[1]. held stays high with no further pulses. On release, held clears on the same edge as fall[1].
5. Reset mid-count: raw_in[0]=1 for 3 cycles, assert reset_n=0 asynchronously mid-cycle -> outputs 0 immediately and no rise. After release with raw still 1 -> rise 6 edges after release.
6. INIT_LEVEL=1, raw_in=all 1 through reset -> debounced all 1, no pulses. Drive raw_in[0]=0 -> fall[0] after 6 edges.
